// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - load-use/mult-div stall, operand forwarding select and stall counter
module pipe_hazard_ctrl #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  d_rs_addr,
    input  logic [4:0]  d_rt_addr,
    input  logic        d_rs_used,
    input  logic        d_rt_used,
    input  logic        d_hilo_read,
    input  logic        d_md_start,
    input  logic        d_md_is_div,
    input  logic [4:0]  e_rf_waddr,
    input  logic        e_rf_wena,
    input  logic        e_dmem_rena,
    input  logic [4:0]  m_rf_waddr,
    input  logic        m_rf_wena,
    output logic        stall_pc,
    output logic        stall_fd,
    output logic        bubble_de,
    output logic [1:0]  fwd_rs_sel,
    output logic [1:0]  fwd_rt_sel,
    output logic        md_busy,
    output logic        md_done,
    output logic [15:0] stall_cycles
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    localparam logic [5:0] MUL_CNT = 6'(MUL_CYCLES);
    localparam logic [5:0] DIV_CNT = 6'(DIV_CYCLES);

    logic [0:0]  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        md_done_q, md_done_d;
    logic [15:0] stall_cycles_q, stall_cycles_d;

    logic load_use;
    logic md_stall;
    logic stall;

    // A load result only exists after MEM, so an EXE-stage load can never forward.
    function automatic logic [1:0] fwd_sel(
        input logic       used,
        input logic [4:0] addr,
        input logic [4:0] e_addr,
        input logic       e_wena,
        input logic       e_load,
        input logic [4:0] m_addr,
        input logic       m_wena
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (used && e_wena && !e_load && e_addr != 5'd0 && e_addr == addr) begin
            sel = 2'b01;
        end else if (used && m_wena && m_addr != 5'd0 && m_addr == addr) begin
            sel = 2'b10;
        end
        return sel;
    endfunction

    always_comb begin
        load_use = e_dmem_rena && e_rf_wena && (e_rf_waddr != 5'd0) &&
                   ((d_rs_used && d_rs_addr == e_rf_waddr) ||
                    (d_rt_used && d_rt_addr == e_rf_waddr));
        md_stall = (state_q == BUSY) && (d_hilo_read || d_md_start);
        stall    = load_use || md_stall;
    end

    assign stall_pc     = stall;
    assign stall_fd     = stall;
    assign bubble_de    = stall;
    assign fwd_rs_sel   = fwd_sel(d_rs_used, d_rs_addr, e_rf_waddr, e_rf_wena, e_dmem_rena,
                                  m_rf_waddr, m_rf_wena);
    assign fwd_rt_sel   = fwd_sel(d_rt_used, d_rt_addr, e_rf_waddr, e_rf_wena, e_dmem_rena,
                                  m_rf_waddr, m_rf_wena);
    assign md_busy      = (state_q == BUSY);
    assign md_done      = md_done_q;
    assign stall_cycles = stall_cycles_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        md_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (d_md_start && !load_use) begin
                    cnt_d   = d_md_is_div ? DIV_CNT : MUL_CNT;
                    state_d = BUSY;
                end
            end
            default: begin
                if (cnt_q == 6'd1) begin
                    state_d   = IDLE;
                    cnt_d     = 6'd0;
                    md_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end
        endcase
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall && stall_cycles_q != 16'hFFFF) begin
            stall_cycles_d = stall_cycles_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= 6'd0;
            md_done_q      <= 1'b0;
            stall_cycles_q <= 16'd0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            md_done_q      <= md_done_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  d_rs_addr, d_rt_addr;
    logic        d_rs_used, d_rt_used, d_hilo_read, d_md_start, d_md_is_div;
    logic [4:0]  e_rf_waddr;
    logic        e_rf_wena, e_dmem_rena;
    logic [4:0]  m_rf_waddr;
    logic        m_rf_wena;
    logic        stall_pc, stall_fd, bubble_de;
    logic [1:0]  fwd_rs_sel, fwd_rt_sel;
    logic        md_busy, md_done;
    logic [15:0] stall_cycles;

    int tests = 0;
    int fails = 0;
    logic [15:0] exp_stalls;

    pipe_hazard_ctrl #(.MUL_CYCLES(4), .DIV_CYCLES(32)) dut (
        .clk(clk), .rst(rst),
        .d_rs_addr(d_rs_addr), .d_rt_addr(d_rt_addr),
        .d_rs_used(d_rs_used), .d_rt_used(d_rt_used),
        .d_hilo_read(d_hilo_read), .d_md_start(d_md_start), .d_md_is_div(d_md_is_div),
        .e_rf_waddr(e_rf_waddr), .e_rf_wena(e_rf_wena), .e_dmem_rena(e_dmem_rena),
        .m_rf_waddr(m_rf_waddr), .m_rf_wena(m_rf_wena),
        .stall_pc(stall_pc), .stall_fd(stall_fd), .bubble_de(bubble_de),
        .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel),
        .md_busy(md_busy), .md_done(md_done), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        d_rs_addr = 5'd0; d_rt_addr = 5'd0; d_rs_used = 1'b0; d_rt_used = 1'b0;
        d_hilo_read = 1'b0; d_md_start = 1'b0; d_md_is_div = 1'b0;
        e_rf_waddr = 5'd0; e_rf_wena = 1'b0; e_dmem_rena = 1'b0;
        m_rf_waddr = 5'd0; m_rf_wena = 1'b0;
    endtask

    task automatic set_load5_use();
        e_dmem_rena = 1'b1; e_rf_wena = 1'b1; e_rf_waddr = 5'd5;
        d_rs_used = 1'b1; d_rs_addr = 5'd5;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        #1;
        tests++; if (md_busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0b expected 0", md_busy); end
        tests++; if (md_done !== 1'b0) begin fails++; $display("FAIL reset_done: got %0b expected 0", md_done); end
        tests++; if (stall_cycles !== 16'd0) begin fails++; $display("FAIL reset_stall_cycles: got %0h expected 0", stall_cycles); end
        tests++; if (stall_pc !== 1'b0) begin fails++; $display("FAIL reset_stall_idle: got %0b expected 0", stall_pc); end
        set_load5_use();
        m_rf_wena = 1'b1; m_rf_waddr = 5'd9; d_rt_used = 1'b1; d_rt_addr = 5'd9;
        #1;
        tests++; if (stall_pc !== 1'b1) begin fails++; $display("FAIL reset_comb_stall: got %0b expected 1", stall_pc); end
        tests++; if (fwd_rt_sel !== 2'b10) begin fails++; $display("FAIL reset_comb_fwd: got %0b expected 10", fwd_rt_sel); end
        @(posedge clk); #1;
        tests++; if (stall_cycles !== 16'd0) begin fails++; $display("FAIL reset_no_count: got %0h expected 0", stall_cycles); end
        clear_inputs();
        @(negedge clk);
        rst = 1'b0;
        exp_stalls = 16'd0;
    endtask

    task automatic test_load_use();
        @(negedge clk);
        set_load5_use();
        #1;
        tests++; if ({stall_pc, stall_fd, bubble_de} !== 3'b111) begin fails++; $display("FAIL load_use_stall: got %b expected 111", {stall_pc, stall_fd, bubble_de}); end
        tests++; if (fwd_rs_sel !== 2'b00) begin fails++; $display("FAIL load_no_fwd: got %0b expected 00", fwd_rs_sel); end
        @(negedge clk);
        exp_stalls = exp_stalls + 16'd1;
        clear_inputs();
        #1;
        tests++; if (stall_pc !== 1'b0) begin fails++; $display("FAIL load_use_release: got %0b expected 0", stall_pc); end
        tests++; if (stall_cycles !== exp_stalls) begin fails++; $display("FAIL load_use_count: got %0h expected %0h", stall_cycles, exp_stalls); end
        // rt match through rt port; then register 0 never stalls
        e_dmem_rena = 1'b1; e_rf_wena = 1'b1; e_rf_waddr = 5'd12; d_rt_used = 1'b1; d_rt_addr = 5'd12;
        #1;
        tests++; if (stall_pc !== 1'b1) begin fails++; $display("FAIL load_use_rt: got %0b expected 1", stall_pc); end
        e_rf_waddr = 5'd0; d_rt_addr = 5'd0;
        #1;
        tests++; if (stall_pc !== 1'b0) begin fails++; $display("FAIL load_use_r0: got %0b expected 0", stall_pc); end
        e_rf_waddr = 5'd12; d_rt_addr = 5'd12; d_rt_used = 1'b0;
        #1;
        tests++; if (stall_pc !== 1'b0) begin fails++; $display("FAIL load_use_unused: got %0b expected 0", stall_pc); end
        clear_inputs();
    endtask

    task automatic test_forward();
        @(negedge clk);
        e_rf_wena = 1'b1; e_rf_waddr = 5'd7; m_rf_wena = 1'b1; m_rf_waddr = 5'd7;
        d_rt_used = 1'b1; d_rt_addr = 5'd7;
        #1;
        tests++; if (fwd_rt_sel !== 2'b01) begin fails++; $display("FAIL fwd_exe_prio: got %0b expected 01", fwd_rt_sel); end
        tests++; if (fwd_rs_sel !== 2'b00) begin fails++; $display("FAIL fwd_rs_unused: got %0b expected 00", fwd_rs_sel); end
        tests++; if (stall_pc !== 1'b0) begin fails++; $display("FAIL fwd_no_stall: got %0b expected 0", stall_pc); end
        e_rf_waddr = 5'd3;
        #1;
        tests++; if (fwd_rt_sel !== 2'b10) begin fails++; $display("FAIL fwd_mem: got %0b expected 10", fwd_rt_sel); end
        d_rs_used = 1'b1; d_rs_addr = 5'd3;
        #1;
        tests++; if (fwd_rs_sel !== 2'b01) begin fails++; $display("FAIL fwd_rs_exe: got %0b expected 01", fwd_rs_sel); end
        e_rf_waddr = 5'd0; m_rf_waddr = 5'd0; d_rt_addr = 5'd0; d_rs_addr = 5'd0;
        #1;
        tests++; if (fwd_rt_sel !== 2'b00) begin fails++; $display("FAIL fwd_r0_rt: got %0b expected 00", fwd_rt_sel); end
        tests++; if (fwd_rs_sel !== 2'b00) begin fails++; $display("FAIL fwd_r0_rs: got %0b expected 00", fwd_rs_sel); end
        e_rf_waddr = 5'd7; m_rf_wena = 1'b0; m_rf_waddr = 5'd7; d_rt_addr = 5'd7; e_rf_wena = 1'b0;
        #1;
        tests++; if (fwd_rt_sel !== 2'b00) begin fails++; $display("FAIL fwd_no_wena: got %0b expected 00", fwd_rt_sel); end
        clear_inputs();
    endtask

    task automatic test_div_hilo_stall();
        @(negedge clk);
        d_md_start = 1'b1; d_md_is_div = 1'b1;
        #1;
        tests++; if (stall_pc !== 1'b0) begin fails++; $display("FAIL div_start_stall: got %0b expected 0", stall_pc); end
        @(negedge clk);
        d_md_start = 1'b0; d_hilo_read = 1'b1;
        for (int k = 0; k < 32; k++) begin
            #1;
            tests++; if ({md_busy, md_done, stall_pc} !== 3'b101) begin fails++; $display("FAIL div_busy_%0d: got %b expected 101", k, {md_busy, md_done, stall_pc}); end
            @(negedge clk);
        end
        exp_stalls = exp_stalls + 16'd32;
        #1;
        tests++; if ({md_busy, md_done, stall_pc} !== 3'b010) begin fails++; $display("FAIL div_done: got %b expected 010", {md_busy, md_done, stall_pc}); end
        d_hilo_read = 1'b0;
        @(negedge clk); #1;
        tests++; if (md_done !== 1'b0) begin fails++; $display("FAIL div_done_pulse: got %0b expected 0", md_done); end
        tests++; if (stall_cycles !== exp_stalls) begin fails++; $display("FAIL div_stall_count: got %0h expected %0h", stall_cycles, exp_stalls); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        d_md_start = 1'b1; d_md_is_div = 1'b0;
        @(negedge clk);
        d_md_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            tests++; if ({md_busy, md_done} !== 2'b10) begin fails++; $display("FAIL mul1_busy_%0d: got %b expected 10", k, {md_busy, md_done}); end
            @(negedge clk);
        end
        d_md_start = 1'b1;
        #1;
        tests++; if ({md_busy, md_done, stall_pc} !== 3'b010) begin fails++; $display("FAIL mul2_on_done: got %b expected 010", {md_busy, md_done, stall_pc}); end
        @(negedge clk);
        d_md_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            tests++; if ({md_busy, md_done} !== 2'b10) begin fails++; $display("FAIL mul2_busy_%0d: got %b expected 10", k, {md_busy, md_done}); end
            if (k == 1) begin
                d_md_start = 1'b1;
                #1;
                tests++; if (stall_pc !== 1'b1) begin fails++; $display("FAIL md_start_busy_stall: got %0b expected 1", stall_pc); end
                d_md_start = 1'b0;
            end
            @(negedge clk);
        end
        #1;
        tests++; if ({md_busy, md_done} !== 2'b01) begin fails++; $display("FAIL mul2_done: got %b expected 01", {md_busy, md_done}); end
        tests++; if (stall_cycles !== exp_stalls) begin fails++; $display("FAIL mul_stall_count: got %0h expected %0h", stall_cycles, exp_stalls); end
    endtask

    task automatic test_start_blocked_by_load_use();
        @(negedge clk);
        set_load5_use();
        d_md_start = 1'b1; d_md_is_div = 1'b1;
        #1;
        tests++; if (stall_pc !== 1'b1) begin fails++; $display("FAIL blocked_start_stall: got %0b expected 1", stall_pc); end
        @(negedge clk);
        exp_stalls = exp_stalls + 16'd1;
        clear_inputs();
        #1;
        tests++; if (md_busy !== 1'b0) begin fails++; $display("FAIL blocked_start_busy: got %0b expected 0", md_busy); end
        @(negedge clk); #1;
        tests++; if (md_done !== 1'b0) begin fails++; $display("FAIL blocked_start_done: got %0b expected 0", md_done); end
    endtask

    task automatic test_reset_mid_div();
        logic seen_done;
        @(negedge clk);
        d_md_start = 1'b1; d_md_is_div = 1'b1;
        @(negedge clk);
        d_md_start = 1'b0;
        // accepted edge leaves cnt=32; 22 more edges bring it to 10
        repeat (22) @(negedge clk);
        #1;
        tests++; if (md_busy !== 1'b1) begin fails++; $display("FAIL pre_reset_busy: got %0b expected 1", md_busy); end
        rst = 1'b1;
        #1;
        tests++; if (md_busy !== 1'b0) begin fails++; $display("FAIL async_reset_busy: got %0b expected 0", md_busy); end
        tests++; if (stall_cycles !== 16'd0) begin fails++; $display("FAIL async_reset_count: got %0h expected 0", stall_cycles); end
        @(negedge clk);
        rst = 1'b0;
        exp_stalls = 16'd0;
        seen_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (md_done || md_busy) seen_done = 1'b1;
        end
        tests++; if (seen_done !== 1'b0) begin fails++; $display("FAIL reset_abandon: got %0b expected 0", seen_done); end
    endtask

    task automatic test_saturation();
        @(negedge clk);
        set_load5_use();
        repeat (65534) @(negedge clk);
        #1;
        tests++; if (stall_cycles !== 16'hFFFE) begin fails++; $display("FAIL sat_pre: got %0h expected fffe", stall_cycles); end
        @(negedge clk); #1;
        tests++; if (stall_cycles !== 16'hFFFF) begin fails++; $display("FAIL sat_reach: got %0h expected ffff", stall_cycles); end
        repeat (5) @(negedge clk);
        #1;
        tests++; if (stall_cycles !== 16'hFFFF) begin fails++; $display("FAIL sat_hold: got %0h expected ffff", stall_cycles); end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        exp_stalls = 16'd0;
        test_reset();
        test_load_use();
        test_forward();
        test_div_hilo_stall();
        test_back_to_back();
        test_start_blocked_by_load_use();
        test_reset_mid_div();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have port clk  input  1  pipeline clock; all state updates on its rising edge.
REQ-002 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port d_rs_addr / d_rt_addr  input  5 each  source register numbers of the instruction in ID.
REQ-004 SHALL have port d_rs_used / d_rt_used  input  1 each  ID instruction actually reads rs / rt.
REQ-005 SHALL have port d_hilo_read  input  1  ID instruction reads HI or LO (mfhi/mflo).
REQ-006 SHALL have port d_md_start / d_md_is_div  input  1 each  ID holds a mult/div; 1 = div, 0 = mult.
REQ-007 SHALL have port e_rf_waddr / e_rf_wena / e_dmem_rena  input  5/1/1  destination, write enable, load flag of the instruction in EXE, as held by the ID/EXE register.
REQ-008 SHALL have port m_rf_waddr / m_rf_wena  input  5/1  destination and write enable of the instruction in MEM.
REQ-009 SHALL have port stall_pc / stall_fd  output  1 each  hold PC / hold IF/ID register.
REQ-010 SHALL have port bubble_de  output  1  ID/EXE register loads all-zero control (NOP) this edge.
REQ-011 SHALL have port fwd_rs_sel / fwd_rt_sel  output  2 each  00 regfile, 01 EXE result, 10 MEM result.
REQ-012 SHALL have port md_busy / md_done  output  1 each  iterative mult/div unit occupied / one-cycle completion pulse.
REQ-013 SHALL have port stall_cycles  output  16  saturating count of stalled cycles.
REQ-014 SHALL have parameters MUL_CYCLES, default 4, mult occupancy; DIV_CYCLES, default 32, div occupancy (both 1..63).

Function
REQ-015 SHALL assert load_use when e_dmem_rena & e_rf_wena & e_rf_waddr!=0 and (d_rs_used & d_rs_addr==e_rf_waddr or d_rt_used & d_rt_addr==e_rf_waddr).
REQ-016 SHALL assert md_stall when state==BUSY and (d_hilo_read or d_md_start).
REQ-017 SHALL drive stall_pc = stall_fd = bubble_de = load_use | md_stall, combinationally, same cycle.
REQ-018 SHALL set fwd_rs_sel=01 when d_rs_used, e_rf_wena, !e_dmem_rena, e_rf_waddr!=0, e_rf_waddr==d_rs_addr; else 10 when d_rs_used, m_rf_wena, m_rf_waddr!=0, m_rf_waddr==d_rs_addr; else 00 (EXE has priority over MEM).
REQ-019 SHALL compute fwd_rt_sel identically using d_rt_addr/d_rt_used.
REQ-020 SHALL never forward or stall on register 0.
REQ-021 SHALL implement FSM states IDLE and BUSY with a 6-bit down-counter cnt.
REQ-022 SHALL accept a start in IDLE when d_md_start & !load_use: cnt <= DIV_CYCLES if d_md_is_div else MUL_CYCLES; state <= BUSY.
REQ-023 SHALL in BUSY decrement cnt each cycle; when cnt==1, state <= IDLE, cnt <= 0, md_done <= 1 for exactly the next cycle.
REQ-024 SHALL hold md_busy = (state==BUSY), so busy is high for exactly N cycles after the accepting edge.
REQ-025 SHALL treat the md_done cycle as IDLE: a new d_md_start there is accepted with no stall.
REQ-026 SHALL ignore d_md_start while load_use is high (not accepted, cnt unchanged).
REQ-027 SHALL increment stall_cycles on each edge where stall_pc is high, saturating at 16'hFFFF.

Reset
REQ-028 SHALL on rst high, immediately and regardless of clk: state=IDLE, cnt=0, md_done=0, stall_cycles=0; md_busy=0 hence md_stall=0.
REQ-029 SHALL abandon a BUSY operation on reset mid-operation, with no md_done pulse afterwards.
REQ-030 SHALL keep combinational outputs (stall, fwd) valid from current inputs during reset; md_stall=0.

Verification
REQ-031 SHALL pass: E load to $5 (e_dmem_rena=1,e_rf_wena=1,e_rf_waddr=5), D reads rs=5 -> stall_pc=stall_fd=bubble_de=1 one cycle, stall_cycles 0->1.
REQ-032 SHALL pass: E ALU writes $7, M writes $7, D rt=7 -> fwd_rt_sel=01; E dest changed to $3 -> fwd_rt_sel=10; dest $0 in both -> 00.
REQ-033 SHALL pass: div accepted at edge T -> md_busy high edges T..T+31, md_done high only for cycle after edge T+32; mfhi in D during busy -> stalls until md_done cycle.
REQ-034 SHALL pass: mult accepted, second mult arrives in D on its md_done cycle -> accepted, no stall, md_busy stays high 4 more cycles.
REQ-035 SHALL pass: rst pulsed mid-div at cnt=10 -> md_busy=0 at once, no md_done, stall_cycles=0.
REQ-036 SHALL pass: stall held 65540 cycles -> stall_cycles=16'hFFFF, stays there.
